// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Holds the controller state encoding, the ARM NOP and default geometry.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    localparam int DEF_DEPTH  = 401;
    localparam int DEF_ADDR_W = 9;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Boot byte stream: valid/ready handshake from the UART/debug receiver.
// The receiver drives the master side, the load controller the slave side.
interface imem_load_ctrl_if;
    import imem_ctrl_pkg::*;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );

endinterface

// File: rtl/imem_load_ctrl_byte_packer.sv
// Packs an accepted byte stream into 32-bit little-endian words.
// Lane 0 lands in bits [7:0]; word_done flags the lane-3 accept.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [1:0]  lane,
    output logic        word_done
);

    assign word_done = en && (lane == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= 2'd0;
            word <= 32'd0;
        end else if (clr) begin
            lane <= 2'd0;
            word <= 32'd0;
        end else if (en) begin
            word[{lane, 3'b000} +: 8] <= data;
            lane                      <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction RAM load/fetch sequencer: boots a program, then hands RAM to the CPU.
// Optional IMEM_BOUNDS_CHECK_EN: out-of-range fetches return NOP and set fetch_fault.
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_words,
    imem_load_ctrl_if.slave   byte_if,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       cpu_instr,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded
`ifdef IMEM_BOUNDS_CHECK_EN
    ,
    output logic              fetch_fault
`endif
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    state_t            state;
    logic              byte_ready_q;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   target;
    logic              accept;
    logic              word_done;
    logic [1:0]        lane;

    assign accept  = byte_if.byte_valid && byte_ready_q;
    assign cnt_inc = cnt + ONE_W;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (load_start),
        .en        (accept),
        .data      (byte_if.byte_data),
        .word      (mem_wdata),
        .lane      (lane),
        .word_done (word_done)
    );

    // cnt doubles as the word pointer and the loaded-word count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            byte_ready_q <= 1'b0;
            mem_we       <= 1'b0;
            cpu_run      <= 1'b0;
            cnt          <= '0;
            target       <= '0;
        end else if (load_start) begin
            cnt    <= '0;
            target <= load_words;
            mem_we <= 1'b0;
            if (load_words == '0) begin
                state        <= RUN;
                byte_ready_q <= 1'b0;
                cpu_run      <= 1'b1;
            end else begin
                state        <= LOAD;
                byte_ready_q <= 1'b1;
                cpu_run      <= 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                end
                LOAD: begin
                    if (word_done) begin
                        state        <= WRITE;
                        byte_ready_q <= 1'b0;
                        mem_we       <= (cnt < DEPTH_W);
                    end
                end
                WRITE: begin
                    cnt    <= cnt_inc;
                    mem_we <= 1'b0;
                    if (cnt_inc == target) begin
                        state   <= RUN;
                        cpu_run <= 1'b1;
                    end else begin
                        state        <= LOAD;
                        byte_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    assign byte_if.byte_ready = byte_ready_q;
    assign mem_waddr          = cnt[ADDR_W-1:0];
    assign words_loaded       = cnt;

`ifdef IMEM_BOUNDS_CHECK_EN
    localparam logic [29:0] DEPTH_PC = 30'(DEPTH);

    logic oob;
    logic unused_pc;

    assign oob       = (cpu_pc[31:2] >= DEPTH_PC);
    assign unused_pc = ^{cpu_pc[1:0], lane};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_fault <= 1'b0;
        else if (load_start)
            fetch_fault <= 1'b0;
        else if (state == RUN && oob)
            fetch_fault <= 1'b1;
    end

    always_comb begin
        mem_raddr = '0;
        cpu_instr = NOP_INSTR;
        if (state == RUN && !oob) begin
            mem_raddr = cpu_pc[ADDR_W+1:2];
            cpu_instr = mem_rdata;
        end
    end
`else
    logic unused_pc;

    assign unused_pc = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0], lane};

    always_comb begin
        mem_raddr = '0;
        cpu_instr = NOP_INSTR;
        if (state == RUN) begin
            mem_raddr = cpu_pc[ADDR_W+1:2];
            cpu_instr = mem_rdata;
        end
    end
`endif

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Controller that owns the instruction memory's write port and sequences it against CPU fetch. After reset it holds the processor stalled, receives a program as a byte stream, packs bytes into 32-bit little-endian words, and writes them to consecutive word addresses. It then releases the processor and forwards its fetch address/data path to the memory. It sits between the boot byte source (UART/debug receiver), the single-cycle ARM core's PC/Instr ports and a writable, asynchronous-read instruction RAM.

## Interface
- `DEPTH`, 401: instruction RAM depth in words.
- `ADDR_W`, 9: word-address width, ≥ clog2(DEPTH).
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE immediately.
- `load_start` in 1: one-cycle pulse that begins a program load.
- `load_words` in ADDR_W+1: number of words to load; sampled on `load_start`.
- `byte_valid` in 1: byte source has a byte.
- `byte_data` in 8: byte value.
- `byte_ready` out 1: byte accepted this cycle when `byte_valid && byte_ready`.
- `mem_we` out 1: instruction RAM write enable.
- `mem_waddr` out ADDR_W: RAM write word address.
- `mem_wdata` out 32: RAM write data.
- `mem_raddr` out ADDR_W: RAM read word address.
- `mem_rdata` in 32: RAM asynchronous read data.
- `cpu_pc` in 32: CPU byte fetch address.
- `cpu_instr` out 32: instruction returned to CPU.
- `cpu_run` out 1: CPU may execute; low means the core is held in reset/stall.
- `words_loaded` out ADDR_W+1: words written in the current/last load.

## Operation
- States: IDLE, LOAD, WRITE, RUN.
- IDLE: `byte_ready=0`, `cpu_run=0`. On `load_start`, latch `load_words`, clear the byte lane counter, word pointer and `words_loaded`, and go to LOAD. If `load_words==0`, go directly to RUN.
- LOAD: `byte_ready=1`. Each accepted byte goes into lane `lane_cnt`: lane 0 fills bits [7:0], lane 3 fills bits [31:24]. Then `lane_cnt` increments mod 4. Acceptance of lane 3 moves to WRITE.
- WRITE: one cycle. `byte_ready=0`, `mem_we=1`, `mem_waddr`=word pointer, `mem_wdata`=packed word. Then the word pointer and `words_loaded` increment. If `words_loaded+1==load_words`, go to RUN; otherwise go to LOAD.
- A word pointer ≥ DEPTH suppresses `mem_we`, but the word still counts toward `load_words`.
- RUN: `cpu_run=1`, `byte_ready=0`, `mem_we=0`. `mem_raddr=cpu_pc[ADDR_W+1:2]`; `cpu_pc[1:0]` is ignored. `cpu_instr=mem_rdata`.
- In IDLE/LOAD/WRITE, `mem_raddr=0` and `cpu_instr=32'hE1A00000` (MOV r0,r0 NOP).
- `load_start` in LOAD, WRITE or RUN restarts the load exactly as from IDLE. A partially packed word is discarded. In WRITE, the pending write still completes that cycle.
- `byte_valid` outside LOAD is ignored; no byte is consumed.
- Reset mid-load returns to IDLE. RAM contents already written are kept; all counters clear.

## Timing
- Reset values: state IDLE, `byte_ready=0`, `mem_we=0`, `mem_waddr=0`, `mem_wdata=0`, `cpu_run=0`, `words_loaded=0`, internal lane/pointer 0.
- `byte_ready`, `mem_we`, `mem_waddr`, `mem_wdata` and `cpu_run` are registered or decoded from registered state only.
- Byte throughput is 1 per cycle in LOAD. A word costs 5 cycles: 4 accepts plus 1 WRITE.
- 4th byte accepted at edge N → `mem_we=1` during cycle N..N+1 → `cpu_run=1` from edge N+1 if it was the last word.
- Fetch path (`cpu_pc` → `mem_raddr`, `mem_rdata` → `cpu_instr`) is combinational in RUN, with zero added latency.

## Configuration
- `IMEM_BOUNDS_CHECK_EN` defined: in RUN, if `cpu_pc[31:2] ≥ DEPTH`, then `cpu_instr=32'hE1A00000` and `mem_raddr=0`.
  - Adds output `fetch_fault` (1 bit, reset 0), which is sticky until reset or `load_start`.
- Not defined: the address is truncated to ADDR_W bits with no check, and there is no `fetch_fault` port.

## Structure
- Shared package `imem_ctrl_pkg` holds:
  - the state enum (IDLE, LOAD, WRITE, RUN);
  - `NOP_INSTR = 32'hE1A00000`;
  - default `DEPTH`/`ADDR_W`.
- One sub-module, `byte_packer`, contains the 2-bit lane counter, the 32-bit shift/assemble register, clear, and a `word_done` pulse. The FSM and fetch mux stay in the top module.

## Test plan
- Reset, then `load_start` with `load_words=2`, then bytes 04,10,A0,E3,01,20,A0,E3 back-to-back → writes E3A01004@0 and E3A02001@1. `byte_ready` is low in each WRITE cycle. `cpu_run` rises one cycle after the 2nd write, and `words_loaded=2`.
- RUN with `cpu_pc=0x4` and `0x7` → `mem_raddr=1` both times, and `cpu_instr` equals the RAM word.
- `load_start` with `load_words=0` → RUN on the next edge with no `mem_we`.
- Assert `reset` after 2 of 4 bytes of word 3 → IDLE immediately, all outputs at reset values. Words 0–2 remain in RAM.
- Reload with `DEPTH=4`, `load_words=5` → 4 writes, the 5th suppressed, `words_loaded=5`, then RUN.
- With `IMEM_BOUNDS_CHECK_EN`, `cpu_pc=0x10`, `DEPTH=4` → `cpu_instr=E1A00000` and `fetch_fault=1` until `load_start`.
